// File: rtl/md_unit_pkg.sv
// Shared constants, op encodings and decode helper for the multiply/divide unit.
// Optional MADD/MADDU/MSUB/MSUBU ops are enabled with macro MDU_MADD_EN.
package md_unit_pkg;

  localparam int MD_OP_W = 4;

  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam md_op_t MD_OP_NONE  = 4'd0;
  localparam md_op_t MD_OP_MULT  = 4'd1;
  localparam md_op_t MD_OP_MULTU = 4'd2;
  localparam md_op_t MD_OP_DIV   = 4'd3;
  localparam md_op_t MD_OP_DIVU  = 4'd4;
  localparam md_op_t MD_OP_MTHI  = 4'd5;
  localparam md_op_t MD_OP_MTLO  = 4'd6;
  localparam md_op_t MD_OP_MADD  = 4'd7;
  localparam md_op_t MD_OP_MADDU = 4'd8;
  localparam md_op_t MD_OP_MSUB  = 4'd9;
  localparam md_op_t MD_OP_MSUBU = 4'd10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  typedef struct packed {
    logic start;
    logic is_div;
    logic sgn;
    logic mthi;
    logic mtlo;
`ifdef MDU_MADD_EN
    logic acc;
    logic sub;
`endif
  } md_dec_t;

  // Unknown codes fall through to an all-zero (idle) decode.
  function automatic md_dec_t md_decode(md_op_t op);
    md_dec_t d;
    d = '0;
    case (op)
      MD_OP_MULT: begin
        d.start = 1'b1;
        d.sgn   = 1'b1;
      end
      MD_OP_MULTU: d.start = 1'b1;
      MD_OP_DIV: begin
        d.start  = 1'b1;
        d.is_div = 1'b1;
        d.sgn    = 1'b1;
      end
      MD_OP_DIVU: begin
        d.start  = 1'b1;
        d.is_div = 1'b1;
      end
      MD_OP_MTHI: d.mthi = 1'b1;
      MD_OP_MTLO: d.mtlo = 1'b1;
`ifdef MDU_MADD_EN
      MD_OP_MADD: begin
        d.start = 1'b1;
        d.sgn   = 1'b1;
        d.acc   = 1'b1;
      end
      MD_OP_MADDU: begin
        d.start = 1'b1;
        d.acc   = 1'b1;
      end
      MD_OP_MSUB: begin
        d.start = 1'b1;
        d.sgn   = 1'b1;
        d.acc   = 1'b1;
        d.sub   = 1'b1;
      end
      MD_OP_MSUBU: begin
        d.start = 1'b1;
        d.acc   = 1'b1;
        d.sub   = 1'b1;
      end
`endif
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Latency counter for the multiply/divide unit.
// Loads a cycle count, counts down to zero; done marks the final busy cycle.
module md_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;

  // Load on accepted start, otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and fixed multi-cycle latency.
// Define MDU_MADD_EN to add the accumulate ops (MADD/MADDU/MSUB/MSUBU).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        md_a,
  input  logic [31:0]        md_b,
  output logic               md_busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  md_dec_t   dec;
  md_state_e state_q;
  md_state_e state_d;

  logic        busy_q;
  logic        accept;
  logic        mt_hi_we;
  logic        mt_lo_we;
  logic        cnt_done;
  logic        cnt_busy;
  logic [CNT_W-1:0] lat_val;

  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] res;
  logic        res_wr;

  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  assign dec     = md_decode(md_op);
  assign busy_q  = (state_q == MD_BUSY);
  assign md_busy = busy_q | dec.start;
  assign lat_val = dec.is_div ? CNT_W'(DIV_LAT)
                              : CNT_W'(MULT_LAT);

  md_lat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (lat_val),
    .done     (cnt_done),
    .busy     (cnt_busy)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // Next state; ops arriving while busy are dropped.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mt_hi_we = 1'b0;
    mt_lo_we = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (dec.start) begin
          accept  = 1'b1;
          state_d = MD_BUSY;
        end else begin
          mt_hi_we = dec.mthi;
          mt_lo_we = dec.mtlo;
        end
      end
      MD_BUSY: begin
        if (cnt_done || !cnt_busy)
          state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Sign/zero-extend to 64 bits; low 64 bits of product are exact.
  always_comb begin
    if (dec.sgn) begin
      mul_a = {{32{md_a[31]}}, md_a};
      mul_b = {{32{md_b[31]}}, md_b};
    end else begin
      mul_a = {32'b0, md_a};
      mul_b = {32'b0, md_b};
    end
  end

  assign prod = mul_a * mul_b;

  // Sign-magnitude divide: quotient truncates toward zero,
  // remainder follows dividend; MIN/-1 wraps naturally.
  assign a_neg = dec.sgn & md_a[31];
  assign b_neg = dec.sgn & md_b[31];
  assign a_mag = a_neg ? (32'd0 - md_a) : md_a;
  assign b_mag = b_neg ? (32'd0 - md_b) : md_b;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  // Select the 64-bit result that will land in {hi,lo}.
  always_comb begin
    res    = prod;
    res_wr = 1'b1;
    if (dec.is_div) begin
      res    = {rem, quot};
      res_wr = (md_b != '0);
    end
`ifdef MDU_MADD_EN
    else if (dec.acc) begin
      if (dec.sub) res = {hi, lo} - prod;
      else         res = {hi, lo} + prod;
    end
`endif
  end

  // Capture the result at the start edge; written back at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (accept) begin
      pend_hi <= res[63:32];
      pend_lo <= res[31:0];
      pend_wr <= res_wr;
    end
  end

  // Architectural HI/LO: completion write-back or MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (busy_q && cnt_done) begin
      if (pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else begin
      if (mt_hi_we) hi <= md_a;
      if (mt_lo_we) lo <= md_a;
    end
  end

endmodule
